limb_wb_bridge_v2: RTL and testbench
====================================

Name: limb_wb_bridge_v2

Overview:
Parametrised single-clock LIMB(EC)-to-Wishbone master, generalising the LIMB glue to configurable address/data widths. It serialises byte-wide LIMB transfers into Wishbone classic cycles on limb_clk. It adds a burst word counter, a bus-error/timeout path with a sticky status flag, and nwait flow control. It sits between the EC's LIMB pins (the toplevel merges d_in/d_out/d_oe into an inout) and the northbridge Wishbone interconnect.

Parameters:
ADDR_W, 36, Wishbone address width; LIMB address bytes ADDR_BYTES = ceil(ADDR_W/8) (localparam).
DATA_BYTES, 4, data word width in bytes (1..8); DW = 8*DATA_BYTES.
TIMEOUT, 255, maximum cycles with wb_cyc_o high before forced abort; 0 disables.
TO_W, 8, timeout counter width; TIMEOUT < 2^TO_W.

Ports:
limb_clk  in  1  clock for LIMB and Wishbone sides
reset  in  1  synchronous, active-high
limb_d_in  in  8  LIMB byte in
limb_d_out  out  8  LIMB byte out
limb_d_oe  out  1  drive enable for limb_d_out
limb_nrd  in  1  0 = read, sampled at first data slot
limb_start  in  1  begins transaction; byte on d_in is address LSB
limb_nwait  out  1  0 = host must hold; byte slots frozen
wb_adr_o  out  ADDR_W  word address
wb_dat_o  out  DW  write data
wb_dat_i  in  DW  read data
wb_sel_o  out  DATA_BYTES  always all ones
wb_we_o  out  1  write strobe
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe (equals wb_cyc_o)
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
bus_err  out  1  sticky error since last accepted limb_start
burst_cnt  out  16  words completed since last accepted limb_start, saturating at 0xFFFF

Behaviour:
- Reset: state IDLE. Outputs: wb_cyc_o/stb/we 0, wb_adr_o 0, wb_dat_o 0, limb_nwait 1, limb_d_oe 0, limb_d_out 0, bus_err 0, burst_cnt 0.
- Slot: a limb_clk edge with limb_nwait=1. When nwait=0, limb_d_in, limb_nrd and limb_start are ignored and all byte state is frozen.
- States: IDLE, ADDR(i), DATA0, WR(j), WR_WAIT, RD_WAIT, RD(j). All registered.
- limb_start slot, from any state: address byte 0 <= d_in; bus_err, burst_cnt cleared. Next state ADDR(1), or DATA0 when ADDR_BYTES=1. In IDLE, slots without start are ignored.
- ADDR(i): byte i <= d_in, LSB first. Bits above ADDR_W are discarded. After the last byte go to DATA0.
- DATA0, nrd=1: byte 0 of the write buffer <= d_in, then WR(1). Each WR(j) slot captures byte j. The slot capturing byte DATA_BYTES-1 loads wb_dat_o, raises cyc/stb/we and drops nwait on the same edge, then enters WR_WAIT. With DATA_BYTES=1 this happens directly from DATA0.
- DATA0, nrd=0: d_in is ignored. cyc/stb high, we low, nwait low on that edge; enter RD_WAIT.
- Termination in WR_WAIT/RD_WAIT, first edge with ack, err, or timeout:
  - cyc/stb/we drop and nwait rises on that edge.
  - wb_adr_o <= wb_adr_o+1, wrapping mod 2^ADDR_W.
  - burst_cnt increments.
  - A read latches wb_dat_i into the read buffer (all 0xFF on err/timeout) and enters RD(0).
  - A write returns to DATA0.
- ack and err together count as err. err or timeout sets bus_err; a write that errors is simply dropped.
- Timeout counter: cleared when cyc rises, increments each cycle cyc is high. Reaching TIMEOUT forces termination on that edge.
- RD(j): limb_d_out = read-buffer byte j (combinational from state). limb_d_oe = !limb_nrd in RD states, else 0. Each slot advances j; after byte DATA_BYTES-1 return to DATA0.
- A limb_start slot during RD(j) or WR(j) discards the partial word with no Wishbone cycle issued.
- reset mid-Wishbone-cycle drops cyc on that edge.
- Read round-trip minimum: 2 edges from the DATA0 slot to first RD byte with zero-wait ack.

Test Plan:
- Defaults; start at 0x21, address bytes 43 65 87 09, nrd=1, data 11 22 33 44 -> one cycle, we=1, adr 0x987654321, dat 0x44332211, sel 0xF; nwait low until ack.
- Same address, nrd=0, slave returns 0xDEADBEEF after 3 waits -> nwait low 4 cycles; d_out EF BE AD DE with d_oe=1; adr then 0x987654322.
- Burst of 3 writes to 0xFFFFFFFFF -> adr sequence 0xFFFFFFFFF, 0x000000000, 0x000000001; burst_cnt=3.
- Read with no ack -> cyc falls after exactly 255 high cycles; d_out FF FF FF FF; bus_err=1, cleared by next limb_start.
- wb_err_i and wb_ack_i asserted together on a write -> bus_err=1, adr increments, no data loss on the following write.
- limb_start after 2 of 4 write bytes, then reset held during RD_WAIT -> no Wishbone cycle for the partial word; cyc=0 and nwait=1 the cycle after reset.

Source files
------------

// File: rtl/limb_wb_bridge_v2.sv
// LIMB (EC byte bus) to Wishbone classic master, parametrised in address and data width.
// Serialises byte slots into word cycles, with burst counting, timeout abort and sticky error.
module limb_wb_bridge_v2 #(
  parameter int ADDR_W     = 36,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                    limb_clk,
  input  logic                    reset,
  input  logic [7:0]              limb_d_in,
  output logic [7:0]              limb_d_out,
  output logic                    limb_d_oe,
  input  logic                    limb_nrd,
  input  logic                    limb_start,
  output logic                    limb_nwait,
  output logic [ADDR_W-1:0]       wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  output logic [DATA_BYTES-1:0]   wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    bus_err,
  output logic [15:0]             burst_cnt
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int DW         = 8 * DATA_BYTES;
  localparam int MAXB       = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int IDX_W      = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA0, S_WR, S_WR_WAIT, S_RD_WAIT, S_RD
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [DW-1:0]         wr_buf_q, wr_buf_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [DW-1:0]         rd_buf_q, rd_buf_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  nwait_q, nwait_d;
  logic                  bus_err_q, bus_err_d;
  logic [15:0]           burst_q, burst_d;
  logic [TO_W-1:0]       to_q, to_d;

  logic [8*ADDR_BYTES-1:0] adr_ext;
  logic [DW-1:0]           wr_ext;
  logic [TO_W:0]           to_inc;
  logic                    timeout_hit;
  logic                    xfer_fail;

  // to_q counts completed high cycles minus one, so the abort lands on edge TIMEOUT
  assign to_inc      = {1'b0, to_q} + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (to_inc == (TO_W+1)'(TIMEOUT));

  always_ff @(posedge limb_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      adr_q     <= '0;
      wr_buf_q  <= '0;
      dat_q     <= '0;
      rd_buf_q  <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      nwait_q   <= 1'b1;
      bus_err_q <= 1'b0;
      burst_q   <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      wr_buf_q  <= wr_buf_d;
      dat_q     <= dat_d;
      rd_buf_q  <= rd_buf_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      nwait_q   <= nwait_d;
      bus_err_q <= bus_err_d;
      burst_q   <= burst_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    wr_buf_d  = wr_buf_q;
    dat_d     = dat_q;
    rd_buf_d  = rd_buf_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    nwait_d   = nwait_q;
    bus_err_d = bus_err_q;
    burst_d   = burst_q;
    to_d      = to_q;
    xfer_fail = 1'b0;
    adr_ext   = '0;
    adr_ext[ADDR_W-1:0] = adr_q;
    wr_ext    = wr_buf_q;
    wr_ext[8*idx_q +: 8] = limb_d_in;

    if (cyc_q) begin
      // Byte slots are frozen (nwait low) for the whole Wishbone cycle
      to_d = to_q + 1'b1;
      if (wb_ack_i || wb_err_i || timeout_hit) begin
        xfer_fail = wb_err_i || (timeout_hit && !wb_ack_i);
        cyc_d     = 1'b0;
        we_d      = 1'b0;
        nwait_d   = 1'b1;
        adr_d     = adr_q + 1'b1;
        idx_d     = '0;
        if (burst_q != 16'hFFFF) burst_d = burst_q + 16'd1;
        if (xfer_fail) bus_err_d = 1'b1;
        if (state_q == S_RD_WAIT) begin
          rd_buf_d = xfer_fail ? '1 : wb_dat_i;
          state_d  = S_RD;
        end else begin
          state_d  = S_DATA0;
        end
      end
    end else if (nwait_q) begin
      if (limb_start) begin
        adr_ext[7:0] = limb_d_in;
        adr_d        = adr_ext[ADDR_W-1:0];
        bus_err_d    = 1'b0;
        burst_d      = '0;
        if (ADDR_BYTES == 1) begin
          state_d = S_DATA0;
          idx_d   = '0;
        end else begin
          state_d = S_ADDR;
          idx_d   = IDX_W'(1);
        end
      end else begin
        case (state_q)
          S_ADDR: begin
            adr_ext[8*idx_q +: 8] = limb_d_in;
            adr_d = adr_ext[ADDR_W-1:0];
            if (idx_q == IDX_W'(ADDR_BYTES-1)) begin
              state_d = S_DATA0;
              idx_d   = '0;
            end else begin
              idx_d   = idx_q + 1'b1;
            end
          end
          S_DATA0, S_WR: begin
            if (state_q == S_DATA0 && !limb_nrd) begin
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              nwait_d = 1'b0;
              to_d    = '0;
              state_d = S_RD_WAIT;
            end else begin
              // idx_q is zero in DATA0, so both states share the byte capture
              wr_buf_d = wr_ext;
              if (idx_q == IDX_W'(DATA_BYTES-1)) begin
                dat_d   = wr_ext;
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                nwait_d = 1'b0;
                to_d    = '0;
                state_d = S_WR_WAIT;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_WR;
              end
            end
          end
          S_RD: begin
            if (idx_q == IDX_W'(DATA_BYTES-1)) begin
              state_d = S_DATA0;
              idx_d   = '0;
            end else begin
              idx_d   = idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign limb_d_out = (state_q == S_RD) ? rd_buf_q[8*idx_q +: 8] : 8'h00;
  assign limb_d_oe  = (state_q == S_RD) && !limb_nrd;
  assign limb_nwait = nwait_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = '1;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign bus_err    = bus_err_q;
  assign burst_cnt  = burst_q;

endmodule

// File: tb/tb_limb_wb_bridge_v2.sv
// Directed plus randomized bench for limb_wb_bridge_v2 with a transaction-level reference model.
module tb_limb_wb_bridge_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        nrd;
  logic        start;
  logic        nwait;
  logic [35:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack, err;
  logic        bus_err;
  logic [15:0] burst;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: expected word address, sticky error and burst count
  logic [35:0] m_adr;
  logic        m_err;
  logic [15:0] m_burst;

  limb_wb_bridge_v2 dut (
    .limb_clk(clk), .reset(rst),
    .limb_d_in(d_in), .limb_d_out(d_out), .limb_d_oe(d_oe),
    .limb_nrd(nrd), .limb_start(start), .limb_nwait(nwait),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_sel_o(sel),
    .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_ack_i(ack), .wb_err_i(err),
    .bus_err(bus_err), .burst_cnt(burst)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic [7:0] d, input logic rd_n, input logic st);
    d_in = d; nrd = rd_n; start = st;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model_word(input logic failed);
    m_adr = m_adr + 36'd1;
    if (m_burst != 16'hFFFF) m_burst = m_burst + 16'd1;
    if (failed) m_err = 1'b1;
  endtask

  task automatic do_start(input logic [35:0] a, input logic [3:0] junk);
    logic [39:0] ext;
    ext = {junk, a};
    slot(ext[7:0], 1'b1, 1'b1);
    m_err = 1'b0; m_burst = 16'd0;
    chk("start_bus_err_clr", bus_err, 1'b0);
    chk("start_burst_clr", burst, 16'd0);
    for (int i = 1; i < 5; i++) slot(ext[8*i +: 8], 1'b1, 1'b0);
    m_adr = a;
    chk("start_cyc_idle", cyc, 1'b0);
  endtask

  // Slave side: hold off for 'waits' cycles, then respond for one edge
  task automatic respond(input int waits, input logic a, input logic e,
                         input logic [31:0] rdata, output int low_cnt);
    low_cnt = 0;
    for (int w = 0; w < waits; w++) begin
      if (nwait === 1'b0) low_cnt++;
      @(posedge clk); @(negedge clk);
    end
    ack = a; err = e; dat_i = rdata;
    if (nwait === 1'b0) low_cnt++;
    @(posedge clk); @(negedge clk);
    ack = 1'b0; err = 1'b0; dat_i = $urandom;
  endtask

  task automatic post_word_checks(input string tag);
    chk({tag, "_cyc_drop"}, cyc, 1'b0);
    chk({tag, "_nwait_up"}, nwait, 1'b1);
    chk({tag, "_adr_next"}, adr, m_adr);
    chk({tag, "_burst"}, burst, m_burst);
    chk({tag, "_bus_err"}, bus_err, m_err);
  endtask

  task automatic wr_word(input logic [31:0] data, input int waits, input logic a, input logic e);
    int low;
    for (int i = 0; i < 4; i++) slot(data[8*i +: 8], 1'b1, 1'b0);
    chk("wr_cyc", cyc, 1'b1);
    chk("wr_stb", stb, 1'b1);
    chk("wr_we", we, 1'b1);
    chk("wr_adr", adr, m_adr);
    chk("wr_dat", dat_o, data);
    chk("wr_sel", sel, 4'hF);
    respond(waits, a, e, 32'($urandom), low);
    chk("wr_nwait_low_cycles", low, waits + 1);
    model_word(e);
    post_word_checks("wr");
  endtask

  task automatic rd_bytes(input logic [31:0] exp);
    for (int j = 0; j < 4; j++) begin
      if (j == 1) begin
        nrd = 1'b1; #1;
        chk("rd_oe_follows_nrd", d_oe, 1'b0);
        nrd = 1'b0; #1;
      end
      chk("rd_byte", d_out, exp[8*j +: 8]);
      chk("rd_oe", d_oe, 1'b1);
      slot(8'($urandom), 1'b0, 1'b0);
    end
    chk("rd_done_oe", d_oe, 1'b0);
    nrd = 1'b1;
  endtask

  task automatic rd_word(input logic [31:0] data, input int waits, input logic e);
    int low;
    slot(8'($urandom), 1'b0, 1'b0);
    chk("rd_cyc", cyc, 1'b1);
    chk("rd_we", we, 1'b0);
    chk("rd_adr", adr, m_adr);
    nrd = 1'b0;
    respond(waits, 1'b1, e, data, low);
    chk("rd_nwait_low_cycles", low, waits + 1);
    model_word(e);
    post_word_checks("rd");
    rd_bytes(e ? 32'hFFFF_FFFF : data);
  endtask

  initial begin
    int n;
    rst = 1'b1; d_in = 8'h00; nrd = 1'b1; start = 1'b0;
    ack = 1'b0; err = 1'b0; dat_i = 32'h0;
    m_adr = '0; m_err = 1'b0; m_burst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_adr", adr, 36'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_nwait", nwait, 1'b1);
    chk("rst_oe", d_oe, 1'b0);
    chk("rst_dout", d_out, 8'h00);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_burst", burst, 16'h0);
    rst = 1'b0;

    // Slots without start in IDLE do nothing
    slot(8'h5A, 1'b1, 1'b0);
    slot(8'h5A, 1'b0, 1'b0);
    chk("idle_ignore_cyc", cyc, 1'b0);
    chk("idle_ignore_adr", adr, 36'h0);

    // Single write, then single read with 3 wait states
    do_start(36'h987654321, 4'h0);
    chk("addr_assembled", adr, 36'h987654321);
    wr_word(32'h44332211, 1, 1'b1, 1'b0);
    do_start(36'h987654321, 4'h0);
    rd_word(32'hDEADBEEF, 3, 1'b0);
    chk("rd_adr_after", adr, 36'h987654322);

    // Burst of writes across the address wrap (junk above bit 35 must be dropped)
    do_start(36'hFFFFFFFFF, 4'hA);
    chk("wrap_addr_mask", adr, 36'hFFFFFFFFF);
    wr_word(32'hA5A5_0001, 0, 1'b1, 1'b0);
    chk("wrap_adr0", adr, 36'h000000000);
    wr_word(32'hA5A5_0002, 2, 1'b1, 1'b0);
    chk("wrap_adr1", adr, 36'h000000001);
    wr_word(32'hA5A5_0003, 0, 1'b1, 1'b0);
    chk("burst_three", burst, 16'd3);

    // Read timeout: no ack ever
    do_start(36'h000001000, 4'h0);
    slot(8'h00, 1'b0, 1'b0);
    nrd = 1'b0;
    n = 0;
    while (cyc === 1'b1 && n < 400) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    chk("timeout_high_cycles", n, 255);
    model_word(1'b1);
    post_word_checks("to");
    rd_bytes(32'hFFFF_FFFF);
    do_start(36'h000002000, 4'h0);

    // ack and err together on a write, then a clean write
    wr_word(32'h1234_5678, 1, 1'b1, 1'b1);
    chk("ackerr_sticky", bus_err, 1'b1);
    wr_word(32'h9ABC_DEF0, 0, 1'b1, 1'b0);
    chk("err_stays_sticky", bus_err, 1'b1);

    // Partial write aborted by start, then reset during RD_WAIT
    do_start(36'h0000ABCD0, 4'h0);
    slot(8'h11, 1'b1, 1'b0);
    slot(8'h22, 1'b1, 1'b0);
    chk("partial_no_cyc", cyc, 1'b0);
    do_start(36'h0000ABCE0, 4'h0);
    chk("restart_no_cyc", cyc, 1'b0);
    slot(8'h00, 1'b0, 1'b0);
    chk("abort_rd_cyc", cyc, 1'b1);
    chk("abort_rd_adr", adr, 36'h0000ABCE0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_cyc", cyc, 1'b0);
    chk("rst_mid_nwait", nwait, 1'b1);
    chk("rst_mid_adr", adr, 36'h0);
    rst = 1'b0; nrd = 1'b1;
    m_adr = '0; m_err = 1'b0; m_burst = '0;

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      logic [35:0] a;
      int words;
      a = {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) a = 36'hFFFFFFFFF - 36'($urandom_range(0, 2));
      do_start(a, 4'($urandom));
      words = $urandom_range(1, 3);
      for (int w = 0; w < words; w++) begin
        logic e;
        e = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 0)
          wr_word(32'($urandom), $urandom_range(0, 3), ($urandom_range(0, 1) == 1) || !e, e);
        else
          rd_word(32'($urandom), $urandom_range(0, 3), e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
